// File: rtl/data_table_ram_responder.sv
// rtl/data_table_ram_responder.sv - data-table RAM storage with fixed-latency read responder
//
// Holds the search data table, answers rd_en_i with rd_data_o exactly
// RAM_LATENCY cycles later, accepts insert/delete writes and zeroes the whole
// table after reset before raising init_done_o.
//
// Ports:
//   clk_i          clock
//   rst_n_i        asynchronous reset, active low
//   rd_addr_i      read address
//   rd_en_i        read request, one per cycle, never stalled
//   rd_data_o      read data, holds last value while rd_data_val_o is low
//   rd_data_val_o  rd_en_i delayed by RAM_LATENCY cycles
//   wr_addr_i      write address
//   wr_data_i      write data
//   wr_en_i        write strobe
//   init_done_o    table cleared, writes accepted
//   wr_drop_o      one-cycle pulse after a write was ignored during CLEAR

module data_table_ram_responder #(
    parameter int A_WIDTH        = 4,
    parameter int D_WIDTH        = 32,
    parameter int RAM_LATENCY    = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [A_WIDTH-1:0] rd_addr_i,
    input  logic               rd_en_i,
    output logic [D_WIDTH-1:0] rd_data_o,
    output logic               rd_data_val_o,
    input  logic [A_WIDTH-1:0] wr_addr_i,
    input  logic [D_WIDTH-1:0] wr_data_i,
    input  logic               wr_en_i,
    output logic               init_done_o,
    output logic               wr_drop_o
);

    localparam int DEPTH = 2 ** A_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [A_WIDTH-1:0] clr_addr_q;
    logic               wr_drop_q;
    logic [D_WIDTH-1:0] issue_data;

    logic [D_WIDTH-1:0] mem [DEPTH];

    // Stage 0 captures the issue-cycle result; the last stage drives the outputs.
    logic [D_WIDTH-1:0]     data_pipe [RAM_LATENCY];
    logic [RAM_LATENCY-1:0] val_pipe;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                // Without clearing, the first edge after release goes straight to READY.
                if (!CLEAR_ON_RESET || (clr_addr_q == {A_WIDTH{1'b1}})) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Result as of the issue cycle. A same-cycle write to the same address wins
    // so the engine sees the table as it stands after this edge. Mid-clear the
    // table is partly stale, so reads return zero instead.
    always_comb begin
        issue_data = '0;
        if (state_q == ST_READY) begin
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                issue_data = wr_data_i;
            end else begin
                issue_data = mem[rd_addr_i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            wr_drop_q  <= 1'b0;
            val_pipe   <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                data_pipe[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_drop_q <= wr_en_i && (state_q == ST_CLEAR);
            if (state_q == ST_CLEAR) begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end
            val_pipe[0] <= rd_en_i;
            if (rd_en_i) begin
                data_pipe[0] <= issue_data;
            end
            // Data only moves with its valid, so the output holds between results.
            for (int i = 1; i < RAM_LATENCY; i++) begin
                val_pipe[i] <= val_pipe[i-1];
                if (val_pipe[i-1]) begin
                    data_pipe[i] <= data_pipe[i-1];
                end
            end
        end
    end

    // Storage array is not reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            if (CLEAR_ON_RESET) begin
                mem[clr_addr_q] <= '0;
            end
        end else if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o     = data_pipe[RAM_LATENCY-1];
    assign rd_data_val_o = val_pipe[RAM_LATENCY-1];
    assign init_done_o   = (state_q == ST_READY);
    assign wr_drop_o     = wr_drop_q;

endmodule

// File: tb/tb_data_table_ram_responder.sv
// tb/tb_data_table_ram_responder.sv - self-checking bench for data_table_ram_responder

module tb_data_table_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;

    logic [31:0] rdata [1:3];
    logic        rval  [1:3];
    logic        done  [1:3];
    logic        drop  [1:3];

    always #5 clk = ~clk;

    // Three instances share stimulus and differ only in read latency.
    for (genvar g = 1; g <= 3; g++) begin : g_dut
        data_table_ram_responder #(
            .A_WIDTH(4),
            .D_WIDTH(32),
            .RAM_LATENCY(g),
            .CLEAR_ON_RESET(1'b1)
        ) u_dut (
            .clk_i(clk),
            .rst_n_i(rst_n),
            .rd_addr_i(rd_addr),
            .rd_en_i(rd_en),
            .rd_data_o(rdata[g]),
            .rd_data_val_o(rval[g]),
            .wr_addr_i(wr_addr),
            .wr_data_i(wr_data),
            .wr_en_i(wr_en),
            .init_done_o(done[g]),
            .wr_drop_o(drop[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: table contents, edges since reset release, and the
    // value each read saw at its issue cycle.
    logic [31:0] m_mem [16];
    int          rel;
    bit          exp_drop;
    bit          hv [$];
    logic [31:0] hd [$];
    logic [31:0] exp_hold [1:3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        bit ev;
        n = hv.size();
        for (int l = 1; l <= 3; l++) begin
            ev = (n >= l) ? hv[n-l] : 1'b0;
            if (ev) exp_hold[l] = hd[n-l];
            check($sformatf("rd_val L%0d t%0d", l, n), {31'd0, rval[l]}, {31'd0, ev});
            check($sformatf("rd_data L%0d t%0d", l, n), rdata[l], exp_hold[l]);
            check($sformatf("init_done L%0d t%0d", l, n), {31'd0, done[l]}, {31'd0, rel >= 16});
            check($sformatf("wr_drop L%0d t%0d", l, n), {31'd0, drop[l]}, {31'd0, exp_drop});
        end
    endtask

    task automatic tick();
        bit          in_clear;
        logic [31:0] v;
        if (rst_n) begin
            in_clear = (rel < 16);
            if (in_clear)                            v = 32'd0;
            else if (wr_en && (wr_addr == rd_addr))  v = wr_data;
            else                                     v = m_mem[rd_addr];
            hv.push_back(rd_en);
            hd.push_back(v);
            exp_drop = in_clear && wr_en;
            if (!in_clear && wr_en) m_mem[wr_addr] = wr_data;
            rel++;
        end
        @(posedge clk);
        #1;
        if (rst_n) check_outputs();
    endtask

    task automatic set_in(input bit re, input int ra, input bit we, input int wa, input logic [31:0] wd);
        rd_en   = re;
        rd_addr = ra[3:0];
        wr_en   = we;
        wr_addr = wa[3:0];
        wr_data = wd;
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 0, 1'b0, 0, 32'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        set_in(1'b0, 0, 1'b0, 0, 32'd0);
        rst_n = 1'b0;
        #1;
        for (int l = 1; l <= 3; l++) begin
            check($sformatf("rst rd_data L%0d", l), rdata[l], 32'd0);
            check($sformatf("rst rd_val L%0d", l), {31'd0, rval[l]}, 32'd0);
            check($sformatf("rst init_done L%0d", l), {31'd0, done[l]}, 32'd0);
            check($sformatf("rst wr_drop L%0d", l), {31'd0, drop[l]}, 32'd0);
        end
        rel      = 0;
        exp_drop = 1'b0;
        hv.delete();
        hd.delete();
        for (int l = 1; l <= 3; l++) exp_hold[l] = 32'd0;
        // Writes during clear are dropped, so the table reads as all zero after it.
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 0, 1'b0, 0, 32'd0);
        @(posedge clk);
        #1;

        // Clear sequence, with a write and reads issued mid-clear.
        do_reset();
        idle(3);
        set_in(1'b1, 9, 1'b1, 5, 32'h0000_1234);
        tick();
        idle(11);
        check("init_done low after 15", {31'd0, done[2]}, 32'd0);
        idle(1);
        check("init_done high after 16", {31'd0, done[2]}, 32'd1);
        for (int a = 0; a < 16; a++) begin
            set_in(1'b1, a, 1'b0, 0, 32'd0);
            tick();
        end
        idle(4);

        // Write then read the next cycle.
        set_in(1'b0, 0, 1'b1, 3, 32'hA5A5_A5A5);
        tick();
        set_in(1'b1, 3, 1'b0, 0, 32'd0);
        tick();
        idle(4);

        // Same-cycle bypass, then a later write that must not disturb it.
        set_in(1'b1, 7, 1'b1, 7, 32'hCAFE_0007);
        tick();
        set_in(1'b0, 0, 1'b1, 7, 32'hBEEF_0007);
        tick();
        idle(4);
        set_in(1'b1, 7, 1'b0, 0, 32'd0);
        tick();
        idle(4);

        // Preload and back-to-back reads.
        for (int a = 0; a < 4; a++) begin
            set_in(1'b0, 0, 1'b1, a, 32'd10 + 32'(a));
            tick();
        end
        for (int a = 0; a < 4; a++) begin
            set_in(1'b1, a, 1'b0, 0, 32'd0);
            tick();
        end
        idle(5);

        // Reset in the middle of clear (clear address 9), then full restart.
        do_reset();
        idle(9);
        do_reset();
        set_in(1'b0, 0, 1'b1, 2, 32'h5555_AAAA);
        tick();
        idle(14);
        check("restart init_done low at 15", {31'd0, done[1]}, 32'd0);
        idle(1);
        check("restart init_done high at 16", {31'd0, done[3]}, 32'd1);
        set_in(1'b1, 2, 1'b0, 0, 32'd0);
        tick();
        set_in(1'b0, 0, 1'b1, 3, 32'h0F0F_0F0F);
        tick();
        set_in(1'b1, 3, 1'b0, 0, 32'd0);
        tick();
        idle(4);

        // Random traffic with frequent address collisions.
        for (int i = 0; i < 500; i++) begin
            set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
            tick();
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
